// File: rtl/midi_cmd_decoder.sv
// midi_cmd_decoder: raw serial-MIDI byte parser driving the decoded event bus.
// Optional feature: define MIDI_RUNNING_STATUS_EN to reuse the last channel status for bare data bytes.
`ifndef MIDI_CMD_SIZE
`define MIDI_CMD_SIZE 3
`endif

module midi_cmd_decoder #(
    parameter int OMNI    = 1,
    parameter int CHANNEL = 0
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      byte_rdy,
    input  logic [7:0]                byte_in,
    output logic                      midi_rdy,
    output logic [`MIDI_CMD_SIZE-1:0] midi_cmd,
    output logic [3:0]                midi_ch_sysn,
    output logic [6:0]                midi_data0,
    output logic [6:0]                midi_data1,
    output logic [7:0]                err_cnt
);

    typedef enum logic [1:0] {ST_IDLE, ST_DATA0, ST_DATA1, ST_SYSEX} state_t;

    state_t     state;
    logic [7:0] status_q;
    logic       status_vld;
    logic [6:0] data0_q;

    logic       is_rt;
    logic       is_status;
    logic       emit_ok;
    logic       fin;
    logic [1:0] byte_len;
    logic [1:0] stat_len;
    logic [6:0] fin_d0;
    logic [6:0] fin_d1;

    // Data bytes following a status; 3 marks statuses that never carry data (F0, F4, F5, F7).
    function automatic logic [1:0] msg_len(input logic [7:0] s);
        if (s[7:4] == 4'hC || s[7:4] == 4'hD) return 2'd1;
        if (s[7:4] != 4'hF) return 2'd2;
        case (s[3:0])
            4'h1, 4'h3: return 2'd1;
            4'h2:       return 2'd2;
            4'h6:       return 2'd0;
            default:    return 2'd3;
        endcase
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] c);
        return (c == 8'hFF) ? c : c + 8'd1;
    endfunction

    function automatic logic keep_status(input logic [7:0] s);
`ifdef MIDI_RUNNING_STATUS_EN
        return (s[7:4] != 4'hF);
`else
        return (s[7:4] != 4'hF) & 1'b0;
`endif
    endfunction

    assign is_rt     = (byte_in[7:3] == 5'b11111);
    assign is_status = byte_in[7] & ~is_rt;
    assign byte_len  = msg_len(byte_in);
    assign stat_len  = msg_len(status_q);
    assign emit_ok   = (OMNI != 0) || (status_q[7:4] == 4'hF) || (status_q[3:0] == CHANNEL[3:0]);

    // A data byte that completes the message in progress.
    always_comb begin
        fin    = 1'b0;
        fin_d0 = byte_in[6:0];
        fin_d1 = 7'd0;
        if (byte_rdy && !byte_in[7]) begin
            case (state)
                ST_IDLE:  fin = status_vld && (stat_len == 2'd1);
                ST_DATA0: fin = (stat_len == 2'd1);
                ST_DATA1: begin
                    fin    = 1'b1;
                    fin_d0 = data0_q;
                    fin_d1 = byte_in[6:0];
                end
                default:  fin = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (byte_rdy && !byte_in[7] && !fin &&
            ((state == ST_IDLE && status_vld) || state == ST_DATA0))
            data0_q <= byte_in[6:0];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            status_q     <= 8'd0;
            status_vld   <= 1'b0;
            midi_rdy     <= 1'b0;
            midi_cmd     <= '0;
            midi_ch_sysn <= 4'd0;
            midi_data0   <= 7'd0;
            midi_data1   <= 7'd0;
            err_cnt      <= 8'd0;
        end else begin
            midi_rdy <= 1'b0;
            if (byte_rdy) begin
                if (is_rt) begin
                    // Realtime slips between bytes without disturbing the parse.
                    midi_rdy     <= 1'b1;
                    midi_cmd     <= byte_in[6:4];
                    midi_ch_sysn <= byte_in[3:0];
                    midi_data0   <= 7'd0;
                    midi_data1   <= 7'd0;
                end else if (is_status) begin
                    if (state == ST_SYSEX && byte_in == 8'hF7) begin
                        state <= ST_IDLE;
                    end else begin
                        // One error per offending byte, whether it aborts a message or is itself stray.
                        if (state == ST_DATA0 || state == ST_DATA1 ||
                            (byte_len == 2'd3 && byte_in != 8'hF0))
                            err_cnt <= sat_inc(err_cnt);
                        case (byte_len)
                            2'd0: begin
                                midi_rdy     <= 1'b1;
                                midi_cmd     <= byte_in[6:4];
                                midi_ch_sysn <= byte_in[3:0];
                                midi_data0   <= 7'd0;
                                midi_data1   <= 7'd0;
                                status_vld   <= 1'b0;
                                state        <= ST_IDLE;
                            end
                            2'd1, 2'd2: begin
                                status_q   <= byte_in;
                                status_vld <= 1'b1;
                                state      <= ST_DATA0;
                            end
                            default: begin
                                status_vld <= 1'b0;
                                state      <= (byte_in == 8'hF0) ? ST_SYSEX : ST_IDLE;
                            end
                        endcase
                    end
                end else if (fin) begin
                    midi_rdy <= emit_ok;
                    if (emit_ok) begin
                        midi_cmd     <= status_q[6:4];
                        midi_ch_sysn <= status_q[3:0];
                        midi_data0   <= fin_d0;
                        midi_data1   <= fin_d1;
                    end
                    status_vld <= keep_status(status_q);
                    state      <= ST_IDLE;
                end else begin
                    case (state)
                        ST_IDLE: begin
                            if (status_vld) state <= ST_DATA1;
                            else            err_cnt <= sat_inc(err_cnt);
                        end
                        ST_DATA0: state <= ST_DATA1;
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_midi_cmd_decoder.sv
// Bench for midi_cmd_decoder: two instances (omni, and channel-1 filtered) driven by directed
// and random byte streams, compared every cycle against a message-level reference model.
`timescale 1ns/1ps
`ifndef MIDI_CMD_SIZE
`define MIDI_CMD_SIZE 3
`endif

module tb_midi_cmd_decoder;

`ifdef MIDI_RUNNING_STATUS_EN
    localparam bit RS = 1'b1;
`else
    localparam bit RS = 1'b0;
`endif

    logic                      clk = 1'b0;
    logic                      reset_n;
    logic                      byte_rdy;
    logic [7:0]                byte_in;
    logic                      rdy  [2];
    logic [`MIDI_CMD_SIZE-1:0] cmd  [2];
    logic [3:0]                chs  [2];
    logic [6:0]                d0   [2];
    logic [6:0]                d1   [2];
    logic [7:0]                errc [2];

    always #5 clk = ~clk;

    midi_cmd_decoder u_dut_omni (
        .clk(clk), .reset_n(reset_n), .byte_rdy(byte_rdy), .byte_in(byte_in),
        .midi_rdy(rdy[0]), .midi_cmd(cmd[0]), .midi_ch_sysn(chs[0]),
        .midi_data0(d0[0]), .midi_data1(d1[0]), .err_cnt(errc[0])
    );

    midi_cmd_decoder #(.OMNI(0), .CHANNEL(1)) u_dut_ch1 (
        .clk(clk), .reset_n(reset_n), .byte_rdy(byte_rdy), .byte_in(byte_in),
        .midi_rdy(rdy[1]), .midi_cmd(cmd[1]), .midi_ch_sysn(chs[1]),
        .midi_data0(d0[1]), .midi_data1(d1[1]), .err_cnt(errc[1])
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference model: message in progress, running status, sysex flag, held event fields.
    int m_rs [2];
    int m_got [2];
    int m_err [2];
    bit m_active [2];
    bit m_sysex [2];
    int m_buf [2][2];
    bit e_rdy [2];
    int e_cmd [2], e_ch [2], e_d0 [2], e_d1 [2];

    function automatic int data_len(input int s);
        if ((s >> 4) == 12 || (s >> 4) == 13 || s == 'hF1 || s == 'hF3) return 1;
        return 2;
    endfunction

    task automatic post(input int k, input int c, input int ch, input int a, input int b);
        e_rdy[k] = 1'b1; e_cmd[k] = c; e_ch[k] = ch; e_d0[k] = a; e_d1[k] = b;
    endtask

    task automatic err_bump(input int k);
        if (m_err[k] < 255) m_err[k]++;
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_rs[k] = -1; m_got[k] = 0; m_err[k] = 0; m_active[k] = 0; m_sysex[k] = 0;
            e_rdy[k] = 0; e_cmd[k] = 0; e_ch[k] = 0; e_d0[k] = 0; e_d1[k] = 0;
        end
    endtask

    task automatic model_byte(input int k, input int b);
        bit bad;
        bad = 1'b0;
        e_rdy[k] = 1'b0;
        if (b >= 'hF8) begin
            post(k, 7, b & 15, 0, 0);
            return;
        end
        if (b >= 'h80) begin
            if (m_sysex[k]) begin
                m_sysex[k] = 1'b0;
                if (b == 'hF7) return;
            end
            if (m_active[k]) bad = 1'b1;
            m_active[k] = 1'b0;
            m_got[k] = 0;
            if (b == 'hF6) begin
                post(k, 7, 6, 0, 0);
                m_rs[k] = -1;
            end else if (b == 'hF0) begin
                m_sysex[k] = 1'b1;
                m_rs[k] = -1;
            end else if (b == 'hF4 || b == 'hF5 || b == 'hF7) begin
                bad = 1'b1;
                m_rs[k] = -1;
            end else begin
                m_rs[k] = b;
                m_active[k] = 1'b1;
            end
            if (bad) err_bump(k);
            return;
        end
        if (m_sysex[k]) return;
        if (!m_active[k]) begin
            if (m_rs[k] < 0) begin
                err_bump(k);
                return;
            end
            m_active[k] = 1'b1;
            m_got[k] = 0;
        end
        m_buf[k][m_got[k]] = b;
        m_got[k]++;
        if (m_got[k] == data_len(m_rs[k])) begin
            if (k == 0 || m_rs[k] >= 'hF0 || (m_rs[k] & 15) == 1)
                post(k, (m_rs[k] >> 4) & 7, m_rs[k] & 15, m_buf[k][0],
                     (m_got[k] == 2) ? m_buf[k][1] : 0);
            m_active[k] = 1'b0;
            if (!(RS && m_rs[k] < 'hF0)) m_rs[k] = -1;
        end
    endtask

    task automatic compare();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rdy[%0d]", k),  32'(rdy[k]),  32'(e_rdy[k]));
            chk($sformatf("err[%0d]", k),  32'(errc[k]), 32'(m_err[k]));
            chk($sformatf("cmd[%0d]", k),  32'(cmd[k]),  32'(e_cmd[k]));
            chk($sformatf("ch[%0d]", k),   32'(chs[k]),  32'(e_ch[k]));
            chk($sformatf("d0[%0d]", k),   32'(d0[k]),   32'(e_d0[k]));
            chk($sformatf("d1[%0d]", k),   32'(d1[k]),   32'(e_d1[k]));
        end
    endtask

    // Called at a falling edge: present one input cycle, then check after the rising edge.
    task automatic step(input bit v, input logic [7:0] b);
        byte_rdy = v;
        byte_in  = b;
        for (int k = 0; k < 2; k++) begin
            if (v) model_byte(k, int'(b));
            else   e_rdy[k] = 1'b0;
        end
        @(negedge clk);
        byte_rdy = 1'b0;
        compare();
    endtask

    task automatic do_reset();
        byte_rdy = 1'b0;
        reset_n  = 1'b0;
        model_reset();
        #2;
        compare();
        @(negedge clk);
        reset_n = 1'b1;
        step(1'b0, 8'h00);
    endtask

    int seq [$];

    task automatic send_seq();
        foreach (seq[i]) step(1'b1, 8'(seq[i]));
    endtask

    logic [7:0] rb;
    int         r;

    initial begin
        reset_n  = 1'b0;
        byte_rdy = 1'b0;
        byte_in  = 8'h00;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        compare();
        reset_n = 1'b1;
        step(1'b0, 8'h00);

        // Note-on, checked against literal values as well as the model.
        seq = '{'h90, 'h3C, 'h64};
        send_seq();
        chk("s1_rdy", 32'(rdy[0]), 32'd1);
        chk("s1_cmd", 32'(cmd[0]), 32'd1);
        chk("s1_ch",  32'(chs[0]), 32'd0);
        chk("s1_d0",  32'(d0[0]),  32'h3C);
        chk("s1_d1",  32'(d1[0]),  32'h64);
        chk("s1_err", 32'(errc[0]), 32'd0);
        step(1'b0, 8'h00);
        chk("s1_pulse", 32'(rdy[0]), 32'd0);

        seq = '{'hB2, 'h4A, 'h10, 'h4A, 'h20};             step(1'b0, 0); send_seq();
        seq = '{'h90, 'h3C, 'hF8, 'h64};                   step(1'b0, 0); send_seq();
        seq = '{'hF0, 'h01, 'h02, 'h03, 'hF7, 'hC5, 'h07}; step(1'b0, 0); send_seq();
        seq = '{'h91, 'h40, 'h7F, 'h92, 'h40, 'h7F};       step(1'b0, 0); send_seq();
        seq = '{'h90, 'h40, 'hA0, 'h41, 'h22, 'hF4, 'hF6, 'hF2, 'h01, 'h02, 'hF1, 'h05};
        send_seq();

        // Saturation and reset mid-message.
        do_reset();
        for (int i = 0; i < 300; i++) step(1'b1, 8'($urandom_range(0, 127)));
        chk("sat0", 32'(errc[0]), 32'hFF);
        chk("sat1", 32'(errc[1]), 32'hFF);
        seq = '{'h93, 'h3C};
        send_seq();
        do_reset();
        seq = '{'h3C, 'h64};
        send_seq();

        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 50)      rb = 8'($urandom_range(0, 127));
            else if (r < 80) rb = 8'($urandom_range(128, 239));
            else if (r < 90) rb = 8'($urandom_range(240, 247));
            else             rb = 8'($urandom_range(248, 255));
            step(1'b1, rb);
            if ($urandom_range(0, 3) == 0) step(1'b0, 8'($urandom_range(0, 255)));
            if ($urandom_range(0, 599) == 0) do_reset();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
